ahb_lite_sram_slave: RTL and testbench
======================================

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 32-bit words; address window 0 to MEM_DEPTH*4-1.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states per OKAY transfer, legal range 0..15.
REQ-003 hclk  input  1  single clock; all state updates on rising edge.
REQ-004 hresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 hsel  input  1  slave select.
REQ-006 haddr  input  32  byte address.
REQ-007 htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 hwrite  input  1  1=write, 0=read.
REQ-009 hsize  input  3  000=byte, 001=halfword, 010=word.
REQ-010 hburst  input  3  accepted, not decoded.
REQ-011 hwdata  input  32  write data, valid in data phase.
REQ-012 hready  input  1  bus-level ready (hreadyin).
REQ-013 hrdata  output  32  read data.
REQ-014 hreadyout  output  1  slave ready.
REQ-015 hresp  output  1  0=OKAY, 1=ERROR.

Function
REQ-016 Address phase accepted only when hsel=1, hready=1 and htrans[1]=1; haddr, hwrite and hsize are latched into a pending-transfer register.
REQ-017 IDLE/BUSY or hsel=0 with hready=1: no access; following data phase is OKAY, zero-wait.
REQ-018 FSM states: S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2.
- S_IDLE: accepted legal transfer goes to S_WAIT if wait count >0, else S_DATA.
- Accepted illegal transfer goes to S_ERR1.
REQ-019 S_WAIT: hreadyout=0, hresp=0; down-counter decrements per cycle; at 1 goes to S_DATA.
REQ-020 S_DATA: hreadyout=1, hresp=0; write commits to memory at the end of this cycle; read drives hrdata combinationally from latched address; a new accepted address phase in the same cycle is pipelined (back-to-back).
REQ-021 Illegal transfer: address >= MEM_DEPTH*4, or address not aligned to hsize, or hsize>010.
REQ-022 Error response is two cycles: S_ERR1 drives hreadyout=0, hresp=1; S_ERR2 drives hreadyout=1, hresp=1; memory is not written; then S_IDLE or next transfer.
REQ-023 Address phases presented while hreadyout=0 are ignored.
REQ-024 Byte lanes are little-endian, selected by haddr[1:0] and hsize; unselected bytes are unchanged.
REQ-025 hrdata returns the full 32-bit word; it is 0 outside S_DATA.
REQ-026 Read issued immediately after a write to the same address returns the new data, with no extra wait.

Reset
REQ-027 hresetn=0 forces hreadyout=1, hresp=0, hrdata=0, state S_IDLE, pending register cleared, wait counter 0.
REQ-028 Reset asserted mid-transfer aborts it; no partial or late write is committed.
REQ-029 Memory contents are not reset.

Configuration
REQ-030 Macro AHB_SLV_WAIT_STATES_EN defined: WAIT_CYCLES wait states are inserted per OKAY transfer, and S_WAIT is present.
REQ-031 Macro undefined: S_WAIT and the counter are omitted, all OKAY transfers are zero-wait, and WAIT_CYCLES is ignored; error timing is unchanged.

Structure
REQ-032 Package ahb_slv_pkg holds:
- htrans_e, hsize_e and state_e typedefs;
- HRESP_OKAY/HRESP_ERROR constants.
REQ-033 Sub-module ahb_slv_mem_array holds the byte-enabled memory: one write port with 4-bit byte enable, one asynchronous read port.

Verification
REQ-034 Zero-wait (macro undefined): NONSEQ write word 0xDEADBEEF to 0x10, then NONSEQ read 0x10 -> hrdata=0xDEADBEEF, hreadyout=1 every cycle, hresp=0.
REQ-035 Wait states (macro defined, WAIT_CYCLES=2): read 0x10 -> exactly 2 cycles hreadyout=0, then 1 data cycle with hreadyout=1, hresp=0.
REQ-036 Byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-037 Write to 0x400 (MEM_DEPTH=256) -> hreadyout 0 then 1 with hresp=1 for both cycles; memory unchanged.
REQ-038 Halfword write to 0x11 (unaligned) -> two-cycle ERROR, then a following read to 0x20 completes OKAY.
REQ-039 Drop hresetn for 1 cycle during S_WAIT of a write to 0x20 -> outputs reach reset values immediately; 0x20 keeps its old data.

Source files
------------

// File: rtl/ahb_slv_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM slave.
// Holds bus encodings, FSM states, response codes and lane/legality helpers.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Little-endian lane select from low address bits and size.
  function automatic logic [3:0] byte_en(
    input logic [1:0] a,
    input logic [1:0] sz
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      sz == 2'b00: be = 4'b0001 << a;
      sz == 2'b01: be = a[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Size must be byte/half/word and address aligned to it.
  function automatic logic size_align_ok(
    input logic [2:0] sz,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      sz == HSIZE_BYTE: ok = 1'b1;
      sz == HSIZE_HALF: ok = !a[0];
      sz == HSIZE_WORD: ok = (a == 2'b00);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_slv_mem_array.sv
// Byte-enabled word memory: one synchronous write port, one async read port.
// Ports: clk, we, be[3:0], waddr, wdata, raddr, rdata. Contents are not reset.
module ahb_slv_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, two-cycle ERROR response.
// Ports: hclk, hresetn, hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
// hready in; hrdata, hreadyout, hresp out. AHB_SLV_WAIT_STATES_EN adds waits.
import ahb_slv_pkg::*;

module ahb_lite_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be 0..15");
  end

  state_e        state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
`ifdef AHB_SLV_WAIT_STATES_EN
  logic [3:0]    cnt_q, cnt_d;
`endif

  logic        ready;
  logic        active;
  logic        accept;
  logic        legal;
  logic        we;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        unused_hburst;

  assign unused_hburst = ^hburst;

  assign ready  = !(state_q == S_WAIT || state_q == S_ERR1);
  assign active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  // Address phases during a stalled data phase are not sampled.
  assign accept = hsel && hready && ready && active;
  assign legal  = ({1'b0, haddr} < MEM_BYTES)
               && size_align_ok(hsize, haddr[1:0]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
`ifdef AHB_SLV_WAIT_STATES_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
`ifdef AHB_SLV_WAIT_STATES_EN
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DATA;
      end
`endif
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      addr_d  = haddr[AW+1:0];
      write_d = hwrite;
      size_d  = hsize[1:0];
      if (!legal) begin
        state_d = S_ERR1;
      end
`ifdef AHB_SLV_WAIT_STATES_EN
      else if (WAIT_CYCLES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
`endif
      else begin
        state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
`ifdef AHB_SLV_WAIT_STATES_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
`ifdef AHB_SLV_WAIT_STATES_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign we = (state_q == S_DATA) && write_q;
  assign be = byte_en(addr_q[1:0], size_q);

  ahb_slv_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (hclk),
    .we    (we),
    .be    (be),
    .waddr (addr_q[AW+1:2]),
    .wdata (hwdata),
    .raddr (addr_q[AW+1:2]),
    .rdata (rdata)
  );

  assign hreadyout = ready;
  assign hresp = (state_q == S_ERR1 || state_q == S_ERR2)
               ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata = (state_q == S_DATA && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed table-driven bench for ahb_lite_sram_slave.
// Works with AHB_SLV_WAIT_STATES_EN defined (2 waits) or undefined.
module tb_ahb_lite_sram_slave;

`ifdef AHB_SLV_WAIT_STATES_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  int n_run  = 0;
  int n_fail = 0;

  assign hready = hreadyout;

  ahb_lite_sram_slave #(
    .MEM_DEPTH   (256),
    .WAIT_CYCLES (2)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (hready),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp)
  );

  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vt [23];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output logic rsp,
                      output int nlow, output logic low_rsp);
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr;
    haddr = a; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    nlow = 0; low_rsp = 1'b0; rd = '0; rsp = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge hclk);
      if (hreadyout) begin
        rd = hrdata; rsp = hresp;
        break;
      end
      nlow++;
      low_rsp |= hresp;
    end
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        rsp;
    logic        lrsp;
    int          nlow;

    vt[0]  = '{1'b1, 32'h010, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 32'h010, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h010, 3'b010, 32'h11223344, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 32'h013, 3'b000, 32'hAA000000, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 32'h010, 3'b010, 32'h0, 32'hAA223344, 1'b0};
    vt[5]  = '{1'b1, 32'h014, 3'b010, 32'h00000000, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 32'h016, 3'b001, 32'hBEEF0000, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 32'h015, 3'b000, 32'h00007700, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 32'h014, 3'b010, 32'h0, 32'hBEEF7700, 1'b0};
    vt[9]  = '{1'b1, 32'h000, 3'b010, 32'h01020304, 32'h0, 1'b0};
    vt[10] = '{1'b1, 32'h3FC, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0};
    vt[11] = '{1'b1, 32'h400, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1};
    vt[12] = '{1'b0, 32'h000, 3'b010, 32'h0, 32'h01020304, 1'b0};
    vt[13] = '{1'b0, 32'h3FC, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0};
    vt[14] = '{1'b1, 32'h020, 3'b010, 32'h20202020, 32'h0, 1'b0};
    vt[15] = '{1'b1, 32'h011, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1};
    vt[16] = '{1'b0, 32'h020, 3'b010, 32'h0, 32'h20202020, 1'b0};
    vt[17] = '{1'b0, 32'h010, 3'b010, 32'h0, 32'hAA223344, 1'b0};
    vt[18] = '{1'b1, 32'h012, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1};
    vt[19] = '{1'b1, 32'h010, 3'b011, 32'hFFFFFFFF, 32'h0, 1'b1};
    vt[20] = '{1'b0, 32'h010, 3'b010, 32'h0, 32'hAA223344, 1'b0};
    vt[21] = '{1'b0, 32'h013, 3'b000, 32'h0, 32'hAA223344, 1'b0};
    vt[22] = '{1'b0, 32'h400, 3'b010, 32'h0, 32'h0, 1'b1};

    hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000; hwdata = '0;
    #12;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    @(negedge hclk); hresetn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].sz, vt[i].wd,
           rd, rsp, nlow, lrsp);
      chk($sformatf("v%0d_lowcycles", i), 32'(nlow),
          vt[i].err ? 32'd1 : 32'(EXP_WAITS));
      chk($sformatf("v%0d_hresp", i), 32'(rsp), 32'(vt[i].err));
      chk($sformatf("v%0d_lowresp", i), 32'(lrsp), 32'(vt[i].err));
      if (!vt[i].wr && !vt[i].err)
        chk($sformatf("v%0d_rdata", i), rd, vt[i].exp);
    end

    // BUSY with hsel=1 must not start an access.
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b01; hwrite = 1'b0;
    haddr = 32'h10; hsize = 3'b010;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("busy_hreadyout", 32'(hreadyout), 32'd1);
    chk("busy_hrdata", hrdata, 32'h0);
    chk("busy_hresp", 32'(hresp), 32'd0);

    // Back-to-back write then read of the same word.
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 32'h30; hsize = 3'b010;
    @(posedge hclk); #1;
    hwrite = 1'b0; hwdata = 32'h600DCAFE;
    nlow = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge hclk);
      if (hreadyout) break;
      nlow++;
    end
    chk("b2b_wr_waits", 32'(nlow), 32'(EXP_WAITS));
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    nlow = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge hclk);
      if (hreadyout) break;
      nlow++;
    end
    chk("b2b_rd_waits", 32'(nlow), 32'(EXP_WAITS));
    chk("b2b_rdata", hrdata, 32'h600DCAFE);
    chk("b2b_hresp", 32'(hresp), 32'd0);
    @(posedge hclk); #1;

    // Reset during a write to 0x20 must abort it.
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 32'h20; hsize = 3'b010;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h99999999;
    #2 hresetn = 1'b0;
    #1;
    chk("midrst_hreadyout", 32'(hreadyout), 32'd1);
    chk("midrst_hresp", 32'(hresp), 32'd0);
    chk("midrst_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    @(negedge hclk); hresetn = 1'b1;
    xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, rsp, nlow, lrsp);
    chk("midrst_keep_rdata", rd, 32'h20202020);
    chk("midrst_keep_waits", 32'(nlow), 32'(EXP_WAITS));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
